i2c_cmd_sequencer: RTL and testbench

- Upstream command stage for the I2C controller.
- Accepts I2C transaction requests through a valid/ready interface and buffers them in a small FIFO.
- Issues requests one at a time on the controller's start/BUSY handshake, then returns read data plus NACK/timeout status on a valid/ready response interface.
- Sits between the system-side register/processor logic and the I2C controller.

---
 rtl/i2c_cmd_sequencer.sv | 169 ++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Command sequencer in front of the I2C controller: queues transaction requests,
// issues them one at a time on the start/BUSY handshake and returns the results.
module i2c_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_op,
    input  logic [6:0]                  cmd_addr,
    input  logic [1:0]                  cmd_nbytes,
    input  logic [15:0]                 cmd_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [15:0]                 rsp_data,
    output logic                        rsp_nack,
    output logic                        rsp_timeout,
    output logic                        ctl_start,
    output logic                        ctl_op,
    output logic [6:0]                  ctl_addr,
    output logic [1:0]                  ctl_nbytes,
    output logic [15:0]                 ctl_d_tx,
    input  logic [15:0]                 ctl_q_rx,
    input  logic                        ctl_busy,
    input  logic                        ctl_nack,
    output logic                        idle,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int EW = 1 + 7 + 2 + 16;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACTIVE, S_RESP} state_t;

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    state_t        r_state;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_ctl_start;
    logic          r_op;
    logic [6:0]    r_addr;
    logic [1:0]    r_nbytes;
    logic [15:0]   r_data;
    logic          r_rsp_valid;
    logic [15:0]   r_rsp_data;
    logic          r_rsp_nack;
    logic          r_rsp_timeout;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_tmo_done;
    logic [EW-1:0] w_head;

    // Ready depends on the registered level only, so a same-cycle pop never frees a slot.
    assign w_full     = (r_level == LW'(FIFO_DEPTH));
    assign w_push     = cmd_valid && !w_full;
    assign w_pop      = (r_state == S_IDLE) && (r_level != '0) && !ctl_busy;
    assign w_tmo_done = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_head     = r_mem[r_rd_ptr];

    assign cmd_ready   = !w_full;
    assign fifo_level  = r_level;
    assign idle        = (r_state == S_IDLE) && (r_level == '0);
    assign ctl_start   = r_ctl_start;
    assign ctl_op      = r_op;
    assign ctl_addr    = r_addr;
    assign ctl_nbytes  = r_nbytes;
    assign ctl_d_tx    = r_data;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_nack    = r_rsp_nack;
    assign rsp_timeout = r_rsp_timeout;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_addr, cmd_nbytes, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tmo_cnt     <= '0;
            r_ctl_start   <= 1'b0;
            r_op          <= 1'b0;
            r_addr        <= '0;
            r_nbytes      <= '0;
            r_data        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_nack    <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_op, r_addr, r_nbytes, r_data} <= w_head;
                        r_ctl_start <= 1'b1;
                        r_tmo_cnt   <= '0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ctl_busy) begin
                        r_ctl_start <= 1'b0;
                        r_tmo_cnt   <= '0;
                        r_state     <= S_ACTIVE;
                    end else if (w_tmo_done) begin
                        r_ctl_start   <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= '0;
                        r_rsp_nack    <= 1'b0;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                S_ACTIVE: begin
                    // NACK is only meaningful once the controller has released BUSY.
                    if (!ctl_busy) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= r_op ? ctl_q_rx : 16'h0000;
                        r_rsp_nack    <= ctl_nack;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (w_tmo_done) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= '0;
                        r_rsp_nack    <= 1'b0;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: table vectors, multi-cycle corner sequences and a
// randomized run scored against a queue-based controller/response model.
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int NRND  = 40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_op;
    logic [6:0]    cmd_addr;
    logic [1:0]    cmd_nbytes;
    logic [15:0]   cmd_data;
    logic          rsp_valid, rsp_ready, rsp_nack, rsp_timeout;
    logic [15:0]   rsp_data;
    logic          ctl_start, ctl_op, ctl_busy, ctl_nack, idle;
    logic [6:0]    ctl_addr;
    logic [1:0]    ctl_nbytes;
    logic [15:0]   ctl_d_tx, ctl_q_rx;
    logic [LW-1:0] fifo_level;

    logic          t_cmd_valid, t_cmd_ready, t_cmd_op;
    logic [6:0]    t_cmd_addr;
    logic [1:0]    t_cmd_nbytes;
    logic [15:0]   t_cmd_data;
    logic          t_rsp_valid, t_rsp_ready, t_rsp_nack, t_rsp_timeout;
    logic [15:0]   t_rsp_data;
    logic          t_ctl_start, t_ctl_op, t_ctl_busy, t_ctl_nack, t_idle;
    logic [6:0]    t_ctl_addr;
    logic [1:0]    t_ctl_nbytes;
    logic [15:0]   t_ctl_d_tx, t_ctl_q_rx;
    logic [LW-1:0] t_fifo_level;

    i2c_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_nbytes(cmd_nbytes), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
        .ctl_start(ctl_start), .ctl_op(ctl_op), .ctl_addr(ctl_addr),
        .ctl_nbytes(ctl_nbytes), .ctl_d_tx(ctl_d_tx), .ctl_q_rx(ctl_q_rx),
        .ctl_busy(ctl_busy), .ctl_nack(ctl_nack),
        .idle(idle), .fifo_level(fifo_level)
    );

    i2c_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_op(t_cmd_op),
        .cmd_addr(t_cmd_addr), .cmd_nbytes(t_cmd_nbytes), .cmd_data(t_cmd_data),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data),
        .rsp_nack(t_rsp_nack), .rsp_timeout(t_rsp_timeout),
        .ctl_start(t_ctl_start), .ctl_op(t_ctl_op), .ctl_addr(t_ctl_addr),
        .ctl_nbytes(t_ctl_nbytes), .ctl_d_tx(t_ctl_d_tx), .ctl_q_rx(t_ctl_q_rx),
        .ctl_busy(t_ctl_busy), .ctl_nack(t_ctl_nack),
        .idle(t_idle), .fifo_level(t_fifo_level)
    );

    typedef struct {
        logic        op;
        logic [6:0]  addr;
        logic [1:0]  nb;
        logic [15:0] data;
        logic [15:0] q_rx;
        logic        nack;
        int          delay;
        int          len;
    } beh_t;

    typedef struct {
        logic [15:0] data;
        logic        nack;
        logic        tmo;
    } exp_t;

    typedef struct {
        beh_t b;
        exp_t e;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   auto_ctl = 1'b1;
    beh_t beh_q[$];
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic push(input logic op, input logic [6:0] addr, input logic [1:0] nb,
                        input logic [15:0] data);
        int n = 0;
        cmd_op = op; cmd_addr = addr; cmd_nbytes = nb; cmd_data = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 5000) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin
            n_checks++;
            $display("FAIL push_wait: cmd_ready still 0 after %0d cycles, expected 1", n);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output bit ok);
        int n = 0;
        while (!rsp_valid && n < 6000) begin @(posedge clk); #1; n++; end
        ok = rsp_valid;
        if (!ok) begin
            n_checks++;
            $display("FAIL %s_wait: rsp_valid 0 after %0d cycles, expected 1", tag, n);
        end
    endtask

    task automatic get_rsp(input string tag, input logic [15:0] ed, input logic en,
                           input logic et, input int stall);
        bit ok;
        wait_rsp(tag, ok);
        if (ok) begin
            check({tag, "_data"}, 32'(rsp_data), 32'(ed));
            check({tag, "_nack"}, 32'(rsp_nack), 32'(en));
            check({tag, "_tmo"}, 32'(rsp_timeout), 32'(et));
            repeat (stall) begin @(posedge clk); #1; end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check({tag, "_drop"}, 32'(rsp_valid), 0);
        end
    endtask

    // Controller model: consumes one behaviour record per observed start pulse.
    initial begin
        beh_t b;
        bit   stable;
        ctl_busy = 1'b0; ctl_q_rx = '0; ctl_nack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (auto_ctl && rst_n && ctl_start && !ctl_busy) begin
                if (beh_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL issue_unexpected: ctl_start=1 with addr 0x%0h, expected no issue", ctl_addr);
                end else begin
                    b = beh_q.pop_front();
                    check("issue_op", 32'(ctl_op), 32'(b.op));
                    check("issue_addr", 32'(ctl_addr), 32'(b.addr));
                    check("issue_nbytes", 32'(ctl_nbytes), 32'(b.nb));
                    check("issue_d_tx", 32'(ctl_d_tx), 32'(b.data));
                    repeat (b.delay) @(posedge clk);
                    #1;
                    check("start_until_busy", 32'(ctl_start), 1);
                    ctl_busy = 1'b1;
                    ctl_q_rx = 16'($urandom);
                    ctl_nack = 1'b1;
                    @(posedge clk); #1;
                    check("start_drop", 32'(ctl_start), 0);
                    stable = 1'b1;
                    for (int i = 0; i < b.len; i++) begin
                        if (ctl_addr !== b.addr || ctl_d_tx !== b.data || ctl_op !== b.op ||
                            ctl_nbytes !== b.nb || ctl_start !== 1'b0 || rsp_valid !== 1'b0)
                            stable = 1'b0;
                        if (i < b.len - 1) begin
                            ctl_q_rx = 16'($urandom);
                            ctl_nack = 1'($urandom);
                            @(posedge clk); #1;
                        end
                    end
                    check("ctl_stable", 32'(stable), 1);
                    ctl_busy = 1'b0;
                    ctl_q_rx = b.q_rx;
                    ctl_nack = b.nack;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run not finished, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [6];
        beh_t rb;
        exp_t re, ce;
        bit   ok, stable, seen;
        int   k;

        tbl[0] = '{'{1'b0, 7'h25, 2'd1, 16'h550F, 16'hBEEF, 1'b0, 3, 200}, '{16'h0000, 1'b0, 1'b0}};
        tbl[1] = '{'{1'b1, 7'h24, 2'd2, 16'h0000, 16'hCE11, 1'b0, 3, 12},  '{16'hCE11, 1'b0, 1'b0}};
        tbl[2] = '{'{1'b1, 7'h24, 2'd2, 16'h0000, 16'hCE11, 1'b1, 3, 12},  '{16'hCE11, 1'b1, 1'b0}};
        tbl[3] = '{'{1'b0, 7'h7F, 2'd3, 16'hA5A5, 16'hFFFF, 1'b1, 2, 5},   '{16'h0000, 1'b1, 1'b0}};
        tbl[4] = '{'{1'b1, 7'h00, 2'd0, 16'h1234, 16'h0000, 1'b0, 1, 1},   '{16'h0000, 1'b0, 1'b0}};
        tbl[5] = '{'{1'b1, 7'h55, 2'd1, 16'hFFFF, 16'h8001, 1'b0, 5, 2},   '{16'h8001, 1'b0, 1'b0}};

        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_nbytes = '0; cmd_data = '0;
        rsp_ready = 1'b0;
        t_cmd_valid = 1'b0; t_cmd_op = 1'b0; t_cmd_addr = '0; t_cmd_nbytes = '0; t_cmd_data = '0;
        t_rsp_ready = 1'b0; t_ctl_busy = 1'b0; t_ctl_nack = 1'b0; t_ctl_q_rx = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_idle", 32'(idle), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_ctl_start", 32'(ctl_start), 0);
        check("rst_fifo_level", 32'(fifo_level), 0);
        check("rst_ctl_addr", 32'(ctl_addr), 0);
        check("rst_ctl_d_tx", 32'(ctl_d_tx), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            beh_q.push_back(tbl[i].b);
            push(tbl[i].b.op, tbl[i].b.addr, tbl[i].b.nb, tbl[i].b.data);
            check($sformatf("v%0d_level", i), 32'(fifo_level), 1);
            check($sformatf("v%0d_start_lat0", i), 32'(ctl_start), 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_start_lat1", i), 32'(ctl_start), 1);
            get_rsp($sformatf("v%0d", i), tbl[i].e.data, tbl[i].e.nack, tbl[i].e.tmo, 0);
        end

        // Response stall: a second command waits while the first response is held.
        beh_q.push_back('{1'b1, 7'h11, 2'd2, 16'h0000, 16'h1234, 1'b1, 2, 5});
        beh_q.push_back('{1'b0, 7'h12, 2'd1, 16'h9876, 16'h4321, 1'b0, 1, 3});
        push(1'b1, 7'h11, 2'd2, 16'h0000);
        push(1'b0, 7'h12, 2'd1, 16'h9876);
        wait_rsp("stall", ok);
        if (ok) begin
            check("stall_data", 32'(rsp_data), 'h1234);
            check("stall_nack", 32'(rsp_nack), 1);
            stable = 1'b1; seen = 1'b0;
            repeat (50) begin
                @(posedge clk); #1;
                if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_nack !== 1'b1 ||
                    rsp_timeout !== 1'b0) stable = 1'b0;
                if (ctl_start) seen = 1'b1;
            end
            check("stall_hold", 32'(stable), 1);
            check("stall_no_start", 32'(seen), 0);
            check("stall_level", 32'(fifo_level), 1);
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            check("stall_drop", 32'(rsp_valid), 0);
            @(posedge clk); #1;
            check("stall_next_start", 32'(ctl_start), 1);
        end
        get_rsp("stall_b", 16'h0000, 1'b0, 1'b0, 0);

        // Backpressure: five commands against a long BUSY.
        for (int i = 0; i < 5; i++) begin
            beh_q.push_back('{1'b1, 7'(8'h30 + i), 2'd1, 16'(i), 16'(16'hA000 + i), 1'(i),
                              1, (i == 0) ? 100 : 3});
        end
        for (int i = 0; i < 5; i++) push(1'b1, 7'(8'h30 + i), 2'd1, 16'(i));
        check("bp_level", 32'(fifo_level), 4);
        check("bp_ready", 32'(cmd_ready), 0);
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (cmd_ready) seen = 1'b1; end
        check("bp_ready_held", 32'(seen), 0);
        get_rsp("bp0", 16'hA000, 1'b0, 1'b0, 0);
        check("bp_ready_before_pop", 32'(cmd_ready), 0);
        @(posedge clk); #1;
        check("bp_ready_after_pop", 32'(cmd_ready), 1);
        check("bp_level_after_pop", 32'(fifo_level), 3);
        for (int i = 1; i < 5; i++)
            get_rsp($sformatf("bp%0d", i), 16'(16'hA000 + i), 1'(i), 1'b0, 0);

        // Randomized traffic against the reference model.
        fork
            begin
                for (int i = 0; i < NRND; i++) begin
                    rb.op    = 1'($urandom);
                    rb.addr  = 7'($urandom);
                    rb.nb    = 2'($urandom);
                    rb.data  = 16'($urandom);
                    rb.q_rx  = 16'($urandom);
                    rb.nack  = 1'($urandom);
                    rb.delay = int'($urandom_range(4, 1));
                    rb.len   = int'($urandom_range(20, 1));
                    re.data  = rb.op ? rb.q_rx : 16'h0000;
                    re.nack  = rb.nack;
                    re.tmo   = 1'b0;
                    beh_q.push_back(rb);
                    exp_q.push_back(re);
                    push(rb.op, rb.addr, rb.nb, rb.data);
                    repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int i = 0; i < NRND; i++) begin
                    wait_rsp("rnd", ok);
                    if (!ok) break;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL rnd_extra: response data 0x%0h with no command outstanding", rsp_data);
                        break;
                    end
                    ce = exp_q.pop_front();
                    get_rsp($sformatf("rnd%0d", i), ce.data, ce.nack, ce.tmo, int'($urandom_range(3, 0)));
                end
            end
        join
        check("rnd_all_issued", 32'(beh_q.size()), 0);

        // Timeout with BUSY never rising (16-cycle instance).
        t_ctl_q_rx = 16'hDEAD; t_ctl_nack = 1'b1;
        t_cmd_op = 1'b1; t_cmd_addr = 7'h3C; t_cmd_nbytes = 2'd2; t_cmd_data = 16'h0101;
        t_cmd_valid = 1'b1;
        @(posedge clk); #1;
        t_cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("tmo1_start", 32'(t_ctl_start), 1);
        k = 0;
        while (!t_rsp_valid && k < 100) begin @(posedge clk); #1; k++; end
        check("tmo1_cycles", 32'(k), 16);
        check("tmo1_flag", 32'(t_rsp_timeout), 1);
        check("tmo1_data", 32'(t_rsp_data), 0);
        check("tmo1_nack", 32'(t_rsp_nack), 0);
        check("tmo1_start_low", 32'(t_ctl_start), 0);
        t_rsp_ready = 1'b1;
        @(posedge clk); #1;
        t_rsp_ready = 1'b0;

        // Timeout with BUSY stuck high in ACTIVE.
        t_cmd_valid = 1'b1;
        @(posedge clk); #1;
        t_cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("tmo2_start", 32'(t_ctl_start), 1);
        t_ctl_busy = 1'b1;
        @(posedge clk); #1;
        check("tmo2_start_drop", 32'(t_ctl_start), 0);
        k = 0;
        while (!t_rsp_valid && k < 100) begin @(posedge clk); #1; k++; end
        check("tmo2_cycles", 32'(k), 16);
        check("tmo2_flag", 32'(t_rsp_timeout), 1);
        check("tmo2_data", 32'(t_rsp_data), 0);
        check("tmo2_nack", 32'(t_rsp_nack), 0);
        t_ctl_busy = 1'b0;
        t_rsp_ready = 1'b1;
        @(posedge clk); #1;
        t_rsp_ready = 1'b0;

        // Reset mid-ACTIVE with two commands queued.
        auto_ctl = 1'b0;
        push(1'b1, 7'h40, 2'd1, 16'h1111);
        @(posedge clk); #1;
        check("rst_pre_start", 32'(ctl_start), 1);
        ctl_busy = 1'b1;
        @(posedge clk); #1;
        push(1'b0, 7'h41, 2'd1, 16'h2222);
        push(1'b0, 7'h42, 2'd1, 16'h3333);
        check("rst_pre_level", 32'(fifo_level), 2);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_start", 32'(ctl_start), 0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        check("rst_mid_level", 32'(fifo_level), 0);
        check("rst_mid_idle", 32'(idle), 1);
        check("rst_mid_ready", 32'(cmd_ready), 1);
        ctl_busy = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (rsp_valid || ctl_start || !idle) seen = 1'b1;
        end
        check("rst_no_rsp_after", 32'(seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
